// File: rtl/matrix_pkg.sv
// Purpose : shared defaults, derived widths and FSM state encoding for the matrix multiply block.
// Latency : n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   N_DEF, DW_DEF   default matrix dimension and element width
//   AW_DEF          address width of an N x N row-major memory
//   ACCW_DEF        accumulator width that holds N*(2^DW-1)^2 without overflow
//   acc_width()     helper so overridden N/DW derive the same way
//   state_e         controller FSM states
package matrix_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 8;

  // A product of two DW-bit values needs 2*DW bits; summing N of them
  // needs clog2(N) extra bits (N is a power of two).
  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  localparam int AW_DEF   = $clog2(N_DEF * N_DEF);
  localparam int ACCW_DEF = acc_width(N_DEF, DW_DEF);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/mac_unit.sv
// Purpose : unsigned multiply-accumulate of two DW-bit operands into an ACCW-bit sum.
// Latency : accumulator register updates on the Clk edge following En; Sum shows the value being loaded.
// Backpressure: none; operands are consumed whenever En is high.
//
// Ports:
//   Clk, nReset    clock and asynchronous active-low reset
//   Clr            load zero into the accumulator (wins over En)
//   En             add Op_A*Op_B into the accumulator
//   Op_A, Op_B     DW-bit unsigned operands
//   Sum            accumulator value after this cycle's update
module mac_unit
  import matrix_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int ACCW = ACCW_DEF
) (
  input  logic            Clk,
  input  logic            nReset,
  input  logic            Clr,
  input  logic            En,
  input  logic [DW-1:0]   Op_A,
  input  logic [DW-1:0]   Op_B,
  output logic [ACCW-1:0] Sum
);

  logic [2*DW-1:0] prod;
  logic [ACCW-1:0] acc_q;
  logic [ACCW-1:0] acc_d;

  assign prod = (2*DW)'(Op_A) * (2*DW)'(Op_B);

  always_comb begin
    acc_d = acc_q;
    if (Clr) begin
      acc_d = '0;
    end else if (En) begin
      acc_d = acc_q + ACCW'(prod);
    end
  end

  // Exposing the next value lets the controller capture the complete dot
  // product (including the product added this cycle) into its own output
  // register, so C_Data can hold while the accumulator is cleared.
  assign Sum = acc_d;

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matrix_mult_ctrl.sv
// Purpose : sequences C = A x B over synchronous-read A/B memories, one C element at a time.
// Latency : N+2 cycles per element, N*N*(N+2) cycles from first RUN to last write, Done one cycle later.
// Backpressure: none; Start is sampled only in IDLE, A/B data must arrive one cycle after its address.
//
// Ports:
//   Clk, nReset      clock and asynchronous active-low reset
//   Start            begin one full multiply (ignored unless idle)
//   Busy             high in every state except IDLE
//   Done             one-cycle pulse after the last C element is written
//   A_Addr, B_Addr   row-major read addresses (registered)
//   A_Data, B_Data   read data, valid one cycle after the address
//   C_We, C_Addr, C_Data  registered write port for the result memory
module matrix_mult_ctrl
  import matrix_pkg::*;
#(
  parameter int  N    = N_DEF,
  parameter int  DW   = DW_DEF,
  localparam int AW   = $clog2(N * N),
  localparam int ACCW = acc_width(N, DW)
) (
  input  logic            Clk,
  input  logic            nReset,
  input  logic            Start,
  output logic            Busy,
  output logic            Done,
  output logic [AW-1:0]   A_Addr,
  output logic [AW-1:0]   B_Addr,
  input  logic [DW-1:0]   A_Data,
  input  logic [DW-1:0]   B_Data,
  output logic            C_We,
  output logic [AW-1:0]   C_Addr,
  output logic [ACCW-1:0] C_Data
);

  localparam int            LW       = $clog2(N);
  localparam logic [LW-1:0] IDX_LAST = LW'(N - 1);
  localparam logic [LW-1:0] IDX_ZERO = '0;

  state_e          state_q, state_d;
  logic [LW-1:0]   i_q, i_d;
  logic [LW-1:0]   j_q, j_d;
  logic [LW-1:0]   k_q, k_d;
  logic [LW-1:0]   i_inc, j_inc, k_inc;

  logic [AW-1:0]   a_addr_q, a_addr_d;
  logic [AW-1:0]   b_addr_q, b_addr_d;
  logic [AW-1:0]   c_addr_q, c_addr_d;
  logic [ACCW-1:0] c_data_q, c_data_d;
  logic            busy_q, done_q, c_we_q;

  logic            mac_clr;
  logic            mac_en;
  logic [ACCW-1:0] mac_sum;

  assign i_inc = i_q + 1'b1;
  assign j_inc = j_q + 1'b1;
  assign k_inc = k_q + 1'b1;

  mac_unit #(
    .DW   (DW),
    .ACCW (ACCW)
  ) u_mac (
    .Clk    (Clk),
    .nReset (nReset),
    .Clr    (mac_clr),
    .En     (mac_en),
    .Op_A   (A_Data),
    .Op_B   (B_Data),
    .Sum    (mac_sum)
  );

  // Addresses are registered, so each branch loads the address that belongs
  // to the state being entered. Because N is a power of two, row*N + col is
  // simply the concatenation {row, col}.
  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    c_addr_d = c_addr_q;
    c_data_d = c_data_q;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d  = ST_RUN;
          i_d      = IDX_ZERO;
          j_d      = IDX_ZERO;
          k_d      = IDX_ZERO;
          mac_clr  = 1'b1;
          a_addr_d = '0;
          b_addr_d = '0;
        end
      end

      ST_RUN: begin
        // Data returned now belongs to the address issued for k-1; at k = 0
        // the read port still carries stale data from the previous element.
        mac_en = (k_q != IDX_ZERO);
        if (k_q == IDX_LAST) begin
          state_d = ST_DRAIN;
        end else begin
          k_d      = k_inc;
          a_addr_d = {i_q, k_inc};
          b_addr_d = {k_inc, j_q};
        end
      end

      ST_DRAIN: begin
        // Last product arrives here; capture the finished dot product.
        mac_en   = 1'b1;
        state_d  = ST_WRITE;
        c_addr_d = {i_q, j_q};
        c_data_d = mac_sum;
      end

      ST_WRITE: begin
        mac_clr = 1'b1;
        if ((i_q == IDX_LAST) && (j_q == IDX_LAST)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
          k_d     = IDX_ZERO;
          if (j_q == IDX_LAST) begin
            j_d = IDX_ZERO;
            i_d = i_inc;
          end else begin
            j_d = j_inc;
          end
          a_addr_d = {i_d, IDX_ZERO};
          b_addr_d = {IDX_ZERO, j_d};
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= ST_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      c_addr_q <= '0;
      c_data_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      c_we_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      c_addr_q <= c_addr_d;
      c_data_q <= c_data_d;
      // Status flags are decoded from the next state so they line up with
      // the state register while still coming straight out of flops.
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_DONE);
      c_we_q   <= (state_d == ST_WRITE);
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign C_We   = c_we_q;
  assign A_Addr = a_addr_q;
  assign B_Addr = b_addr_q;
  assign C_Addr = c_addr_q;
  assign C_Data = c_data_q;

endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// Purpose : self-checking bench for matrix_mult_ctrl against a plain dot-product reference model.
// Latency : n/a.
// Backpressure: n/a.
module tb_matrix_mult_ctrl;

  localparam int N        = 4;
  localparam int DW       = 8;
  localparam int AW       = 4;
  localparam int ACCW     = 2 * DW + 2;
  localparam int NE       = N * N;
  localparam int ELEM_CYC = N + 2;

  logic            Clk;
  logic            nReset;
  logic            Start;
  logic            Busy;
  logic            Done;
  logic [AW-1:0]   A_Addr;
  logic [AW-1:0]   B_Addr;
  logic [DW-1:0]   A_Data;
  logic [DW-1:0]   B_Data;
  logic            C_We;
  logic [AW-1:0]   C_Addr;
  logic [ACCW-1:0] C_Data;

  logic [DW-1:0]   memA [NE];
  logic [DW-1:0]   memB [NE];

  int nvec = 0;
  int nerr = 0;

  int cyc      = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int we_cnt   = 0;
  int last_we  = 0;
  bit busy_prev = 1'b0;
  int              rise_q  [$];
  logic [AW-1:0]   wr_addr [$];
  logic [ACCW-1:0] wr_data [$];

  matrix_mult_ctrl #(
    .N  (N),
    .DW (DW)
  ) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .Start  (Start),
    .Busy   (Busy),
    .Done   (Done),
    .A_Addr (A_Addr),
    .B_Addr (B_Addr),
    .A_Data (A_Data),
    .B_Data (B_Data),
    .C_We   (C_We),
    .C_Addr (C_Addr),
    .C_Data (C_Data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous-read A/B memories.
  always @(posedge Clk) begin
    A_Data <= memA[A_Addr];
    B_Data <= memB[B_Addr];
  end

  // Observer on the falling edge: records activity for the checks below.
  always @(negedge Clk) begin
    cyc = cyc + 1;
    if (Busy) busy_cnt = busy_cnt + 1;
    if (Busy && !busy_prev) rise_q.push_back(cyc);
    busy_prev = Busy;
    if (Done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (C_We) begin
      we_cnt  = we_cnt + 1;
      last_we = cyc;
      wr_addr.push_back(C_Addr);
      wr_data.push_back(C_Data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  // Reference: C[i][j] = sum_k A[i][k] * B[k][j].
  function automatic int ref_c(input int i, input int j);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += int'(memA[i*N + k]) * int'(memB[k*N + j]);
    return s;
  endfunction

  // 0: identity x ramp, 1: all 255, 2: A=r+1 / B=c+1, 3: random
  task automatic fill(input int mode);
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        case (mode)
          0: begin
            memA[r*N + c] = (r == c) ? DW'(1) : DW'(0);
            memB[r*N + c] = DW'(r * 4 + c);
          end
          1: begin
            memA[r*N + c] = DW'(255);
            memB[r*N + c] = DW'(255);
          end
          2: begin
            memA[r*N + c] = DW'(r + 1);
            memB[r*N + c] = DW'(c + 1);
          end
          default: begin
            memA[r*N + c] = DW'($urandom_range(0, 255));
            memB[r*N + c] = DW'($urandom_range(0, 255));
          end
        endcase
      end
    end
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    int t;
    t = 0;
    while (done_cnt < target && t < 400) begin
      tick();
      t++;
    end
    chk({tag, "_done_seen"}, done_cnt >= target, 1);
  endtask

  // Compares n recorded writes from queue index wb with row-major reference.
  task automatic check_writes(input string tag, input int wb, input int n);
    for (int e = 0; e < n; e++) begin
      if (wb + e < wr_addr.size()) begin
        chk($sformatf("%s_addr%0d", tag, e), 32'(wr_addr[wb + e]), e);
        chk($sformatf("%s_data%0d", tag, e), 32'(wr_data[wb + e]), ref_c(e / N, e % N));
      end
    end
  endtask

  task automatic run_check(input string tag, input bit poke_done);
    int wb, db, bb, rb;
    wb = wr_addr.size();
    db = done_cnt;
    bb = busy_cnt;
    rb = rise_q.size();
    start_pulse();
    wait_done(db + 1, tag);
    if (poke_done) begin
      // Now inside the DONE cycle: this Start must be ignored.
      Start = 1'b1;
      tick();
      Start = 1'b0;
      repeat (8) tick();
    end
    repeat (3) tick();
    chk({tag, "_nwrites"}, wr_addr.size() - wb, NE);
    chk({tag, "_ndone"}, done_cnt - db, 1);
    chk({tag, "_busy_cycles"}, busy_cnt - bb, NE * ELEM_CYC + 1);
    chk({tag, "_nruns"}, rise_q.size() - rb, 1);
    if (rise_q.size() > rb)
      chk({tag, "_run_len"}, last_we - rise_q[rb] + 1, NE * ELEM_CYC);
    chk({tag, "_done_after_write"}, done_cyc, last_we + 1);
    check_writes(tag, wb, NE);
  endtask

  initial begin
    int wb, db, rb, wc, d1, t;
    Start  = 1'b0;
    nReset = 1'b0;
    for (int e = 0; e < NE; e++) begin
      memA[e] = '0;
      memB[e] = '0;
    end
    repeat (3) tick();

    // Reset state
    chk("rst_busy",   32'(Busy),   0);
    chk("rst_done",   32'(Done),   0);
    chk("rst_c_we",   32'(C_We),   0);
    chk("rst_a_addr", 32'(A_Addr), 0);
    chk("rst_b_addr", 32'(B_Addr), 0);
    chk("rst_c_addr", 32'(C_Addr), 0);
    chk("rst_c_data", 32'(C_Data), 0);
    nReset = 1'b1;
    repeat (2) tick();

    // Identity x ramp: C equals B
    fill(0);
    wb = wr_addr.size();
    run_check("ident", 1'b0);
    for (int e = 0; e < NE; e++)
      if (wb + e < wr_data.size())
        chk($sformatf("ident_eq_b%0d", e), 32'(wr_data[wb + e]), 32'(memB[e]));

    // Saturated operands: no truncation
    fill(1);
    wb = wr_addr.size();
    run_check("max", 1'b0);
    for (int e = 0; e < NE; e++)
      if (wb + e < wr_data.size())
        chk($sformatf("max_val%0d", e), 32'(wr_data[wb + e]), 260100);

    // Outer-product pattern
    fill(2);
    wb = wr_addr.size();
    run_check("outer", 1'b0);
    if (wb + 15 < wr_data.size()) begin
      chk("outer_c33_addr", 32'(wr_addr[wb + 15]), 15);
      chk("outer_c33_data", 32'(wr_data[wb + 15]), 64);
    end

    // Random matrices
    for (int r = 0; r < 2; r++) begin
      fill(3);
      run_check($sformatf("rand%0d", r), 1'b0);
    end

    // Start pulsed during DONE: no second run
    fill(3);
    run_check("donepoke", 1'b1);

    // Start held high: back-to-back runs
    fill(3);
    wb = wr_addr.size();
    db = done_cnt;
    rb = rise_q.size();
    Start = 1'b1;
    wait_done(db + 1, "held1");
    d1 = done_cyc;
    t = 0;
    while (rise_q.size() <= rb + 1 && t < 10) begin
      tick();
      t++;
    end
    chk("held_restart_seen", rise_q.size() > rb + 1, 1);
    if (rise_q.size() > rb + 1)
      chk("held_restart_gap", rise_q[rb + 1] - d1, 2);
    Start = 1'b0;
    wait_done(db + 2, "held2");
    repeat (10) tick();
    chk("held_ndone", done_cnt - db, 2);
    chk("held_nruns", rise_q.size() - rb, 2);
    chk("held_nwrites", wr_addr.size() - wb, 2 * NE);
    check_writes("held_r1", wb, NE);
    check_writes("held_r2", wb + NE, NE);

    // Reset at cycle 40 of a run
    fill(3);
    wb = wr_addr.size();
    db = done_cnt;
    rb = rise_q.size();
    wc = we_cnt;
    start_pulse();
    chk("abort_started", rise_q.size() - rb, 1);
    repeat (40) tick();
    #2;
    nReset = 1'b0;
    #1;
    chk("abort_busy",   32'(Busy),   0);
    chk("abort_done",   32'(Done),   0);
    chk("abort_c_we",   32'(C_We),   0);
    chk("abort_a_addr", 32'(A_Addr), 0);
    chk("abort_b_addr", 32'(B_Addr), 0);
    chk("abort_c_addr", 32'(C_Addr), 0);
    chk("abort_c_data", 32'(C_Data), 0);
    repeat (3) tick();
    nReset = 1'b1;
    repeat (8) tick();
    // WRITE cycles fall at run cycles 5, 11, ..., 35 before the abort
    chk("abort_nwrites", we_cnt - wc, (40 + 1) / ELEM_CYC);
    chk("abort_ndone", done_cnt - db, 0);
    chk("abort_busy_after", 32'(Busy), 0);
    check_writes("abort_kept", wb, (40 + 1) / ELEM_CYC);

    fill(3);
    run_check("post_rst", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
